// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the RAM-backed FIFO controller.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin slot arbiter; req[0]=read slot, req[1]=write slot.
module rr_arb2 (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       clear,
  input  logic [1:0] req,
  input  logic       fire,
  output logic [1:0] grant
);

  logic prio;

  // Grant the lone requester, or follow prio when both request
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Flip priority only after a contended grant actually transfers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prio <= 1'b0;
    end else if (clear) begin
      prio <= 1'b0;
    end else if ((req == 2'b11) && fire) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/ram4x16_fifo_ctrl.sv
// FIFO controller that time-shares the single RAM port between push and pop.
module ram4x16_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_clr,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              run;
  logic              want_push;
  logic              want_pop;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              push_fire;
  logic              pop_fire;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign run         = (state == RUN) && !flush;
  assign want_push   = push_valid && !full;
  assign want_pop    = !empty;
  assign req         = run ? {want_push, want_pop} : 2'b00;
  assign ram_data_in = push_data;
  assign push_fire   = push_valid && push_ready;
  assign pop_fire    = pop_valid && pop_ready;

  rr_arb2 u_arb (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (!run),
    .req   (req),
    .fire  (push_fire || pop_fire),
    .grant (grant)
  );

  // Drive the RAM port and handshakes for this cycle's slot
  always_comb begin
    push_ready = 1'b0;
    pop_valid  = 1'b0;
    pop_data   = '0;
    ram_rw     = 1'b0;
    ram_addr   = '0;
    ram_clr    = (state == CLEAR);
    if (run) begin
      if (grant[1]) begin
        ram_addr   = wr_ptr;
        ram_rw     = push_valid;
        push_ready = 1'b1;
      end else begin
        ram_addr  = rd_ptr;
        pop_valid = !empty;
        pop_data  = ram_data_out;
      end
    end
  end

  // State, pointers and occupancy
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= CLEAR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          state <= RUN;
        end
        RUN: begin
          if (flush) begin
            state  <= CLEAR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
          end else if (push_fire) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            count  <= count + CNT_W'(1);
          end else if (pop_fire) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            count  <= count - CNT_W'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram4x16_fifo_ctrl.sv
// Self-checking bench for ram4x16_fifo_ctrl with a behavioural RAM and queue model.
module tb_ram4x16_fifo_ctrl;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [15:0] push_data;
  logic        pop_valid;
  logic        pop_ready;
  logic [15:0] pop_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        ram_rw;
  logic [1:0]  ram_addr;
  logic [15:0] ram_data_in;
  logic        ram_clr;
  logic [15:0] ram_data_out;

  ram4x16_fifo_ctrl dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .push_data    (push_data),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .pop_data     (pop_data),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .ram_rw       (ram_rw),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_clr      (ram_clr),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // 4x16 RAM: synchronous write/clear, asynchronous read
  logic [15:0] mem [4];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4; i++) mem[i] <= 16'h0000;
    end else if (ram_rw) begin
      mem[ram_addr] <= ram_data_in;
    end
  end
  assign ram_data_out = mem[ram_addr];

  // Reference model: FIFO as a queue plus slot-priority bit and pointer counters
  bit          m_clear;
  logic [15:0] q[$];
  bit          m_prio;
  int          m_wr;
  int          m_rd;

  bit          e_pr, e_pv, e_rw, e_clr, e_cont;
  logic [1:0]  e_addr;
  logic [15:0] e_pd;

  int checks;
  int failures;

  function void model_reset();
    m_clear = 1'b1;
    q.delete();
    m_prio = 1'b0;
    m_wr   = 0;
    m_rd   = 0;
  endfunction

  function void model_eval();
    bit wp;
    bit wq;
    e_clr  = m_clear;
    e_pr   = 1'b0;
    e_pv   = 1'b0;
    e_rw   = 1'b0;
    e_addr = 2'd0;
    e_pd   = 16'h0000;
    e_cont = 1'b0;
    if (!m_clear && !flush) begin
      wp     = push_valid && (q.size() < 4);
      wq     = (q.size() > 0);
      e_cont = wp && wq;
      if (wp && (!wq || m_prio)) begin
        e_pr   = 1'b1;
        e_rw   = push_valid;
        e_addr = 2'(m_wr);
      end else begin
        e_pv   = wq;
        e_addr = 2'(m_rd);
        if (wq) e_pd = q[0];
      end
    end
  endfunction

  // Advance one clock and apply the expected transfers to the model
  task automatic tick();
    bit pf;
    bit of;
    model_eval();
    pf = e_pr && push_valid;
    of = e_pv && pop_ready;
    @(posedge clk);
    if (m_clear) begin
      m_clear = 1'b0;
    end else if (flush) begin
      model_reset();
    end else begin
      if (pf) begin
        q.push_back(push_data);
        m_wr = (m_wr + 1) % 4;
      end
      if (of) begin
        void'(q.pop_front());
        m_rd = (m_rd + 1) % 4;
      end
      if (e_cont && (pf || of)) m_prio = !m_prio;
    end
    #1;
  endtask

  task automatic drive(input bit pv, input logic [15:0] pd, input bit pr, input bit fl);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    flush      = fl;
  endtask

  task automatic test_reset();
    int clr_cycles;
    clr_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    model_reset();
    #2;
    checks++;
    if ({ram_clr, push_ready, pop_valid, ram_rw, ram_addr, count, empty, full, pop_data} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_values got=%b/%b/%b/%b/%0d/%0d/%b/%b/%h", ram_clr, push_ready,
               pop_valid, ram_rw, ram_addr, count, empty, full, pop_data);
    end
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    clr_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      model_eval();
      if (ram_clr) clr_cycles++;
      checks++;
      if ({push_ready, pop_valid, ram_rw, ram_clr, count, empty} !==
          {e_pr, e_pv, e_rw, e_clr, 3'(q.size()), 1'b1}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b%b%b%b cnt=%0d exp=%b%b%b%b cnt=%0d", c,
                 push_ready, pop_valid, ram_rw, ram_clr, count, e_pr, e_pv, e_rw, e_clr, q.size());
      end
      tick();
    end
    checks++;
    if (clr_cycles !== 1) begin
      failures++;
      $display("FAIL reset_clr_len got=%0d exp=1", clr_cycles);
    end
  endtask

  task automatic test_fill();
    logic [15:0] words [4];
    int idx;
    words[0] = 16'hA1B2; words[1] = 16'hC3D4; words[2] = 16'h1111; words[3] = 16'h2222;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, words[idx % 4], 1'b0, 1'b0);
      #1;
      model_eval();
      checks++;
      if ({push_ready, pop_valid, ram_rw, ram_addr, count, full, empty} !==
          {e_pr, e_pv, e_rw, e_addr, 3'(q.size()), q.size() == 4, q.size() == 0}) begin
        failures++;
        $display("FAIL fill cyc=%0d got=%b%b%b a=%0d cnt=%0d f=%b e=%b exp=%b%b%b a=%0d cnt=%0d",
                 c, push_ready, pop_valid, ram_rw, ram_addr, count, full, empty,
                 e_pr, e_pv, e_rw, e_addr, q.size());
      end
      if (e_pr && idx < 3) idx++;
      tick();
    end
  endtask

  task automatic test_drain();
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      #1;
      model_eval();
      checks++;
      if ({push_ready, pop_valid, ram_rw, ram_addr, count} !==
          {e_pr, e_pv, e_rw, e_addr, 3'(q.size())}) begin
        failures++;
        $display("FAIL drain_ctrl cyc=%0d got=%b%b%b a=%0d cnt=%0d exp=%b%b%b a=%0d cnt=%0d",
                 c, push_ready, pop_valid, ram_rw, ram_addr, count, e_pr, e_pv, e_rw, e_addr, q.size());
      end
      if (e_pv) begin
        checks++;
        if (pop_data !== e_pd) begin
          failures++;
          $display("FAIL drain_data cyc=%0d got=%h exp=%h", c, pop_data, e_pd);
        end
      end
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checks++;
    if ({empty, count, pop_valid} !== {1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL drain_empty got e=%b cnt=%0d pv=%b exp e=1 cnt=0 pv=0", empty, count, pop_valid);
    end
  endtask

  task automatic test_back_to_back();
    int slots_w;
    int slots_r;
    slots_w = 0;
    slots_r = 0;
    drive(1'b1, 16'h5A00, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 16'(16'h5A01 + c), 1'b1, 1'b0);
      #1;
      model_eval();
      if (e_pr) slots_w++; else slots_r++;
      checks++;
      if ({push_ready, pop_valid, ram_rw, ram_addr, count} !==
          {e_pr, e_pv, e_rw, e_addr, 3'(q.size())}) begin
        failures++;
        $display("FAIL b2b_slot cyc=%0d got=%b%b%b a=%0d cnt=%0d exp=%b%b%b a=%0d cnt=%0d",
                 c, push_ready, pop_valid, ram_rw, ram_addr, count, e_pr, e_pv, e_rw, e_addr, q.size());
      end
      if (e_pv) begin
        checks++;
        if (pop_data !== e_pd) begin
          failures++;
          $display("FAIL b2b_data cyc=%0d got=%h exp=%h", c, pop_data, e_pd);
        end
      end
      tick();
    end
    checks++;
    if (slots_w !== 4 || slots_r !== 4) begin
      failures++;
      $display("FAIL b2b_balance got w=%0d r=%0d exp w=4 r=4", slots_w, slots_r);
    end
  endtask

  task automatic test_wrap();
    int next_push;
    int next_pop;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      tick();
    end
    next_push = 1;
    next_pop  = 1;
    for (int c = 0; c < 40 && next_pop <= 6; c++) begin
      drive(next_push <= 6, 16'(next_push), 1'b1, 1'b0);
      #1;
      model_eval();
      checks++;
      if ({push_ready, pop_valid, ram_rw, ram_addr} !== {e_pr, e_pv, e_rw, e_addr}) begin
        failures++;
        $display("FAIL wrap_slot cyc=%0d got=%b%b%b a=%0d exp=%b%b%b a=%0d",
                 c, push_ready, pop_valid, ram_rw, ram_addr, e_pr, e_pv, e_rw, e_addr);
      end
      if (e_pv) begin
        checks++;
        if (pop_data !== 16'(next_pop)) begin
          failures++;
          $display("FAIL wrap_data cyc=%0d got=%h exp=%h", c, pop_data, 16'(next_pop));
        end
        next_pop++;
      end
      if (e_pr && push_valid) next_push++;
      tick();
    end
    checks++;
    if (next_pop !== 7) begin
      failures++;
      $display("FAIL wrap_timeout popped=%0d exp=6", next_pop - 1);
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'(16'hF000 + c), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 16'hF0F0, 1'b1, 1'b1);
    #1;
    checks++;
    if ({push_ready, pop_valid, ram_rw} !== 3'b000) begin
      failures++;
      $display("FAIL flush_gate got=%b%b%b exp=000", push_ready, pop_valid, ram_rw);
    end
    tick();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    checks++;
    if ({ram_clr, count, empty, push_ready, pop_valid} !== {1'b1, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL flush_clear got clr=%b cnt=%0d e=%b pr=%b pv=%b exp clr=1 cnt=0 e=1 pr=0 pv=0",
               ram_clr, count, empty, push_ready, pop_valid);
    end
    tick();
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hCAFE, 1'b0, 1'b0);
    #1;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({ram_clr, count, push_ready, pop_valid, ram_rw} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_clr got clr=%b cnt=%0d pr=%b pv=%b rw=%b exp clr=1 cnt=0 pr=0 pv=0 rw=0",
               ram_clr, count, push_ready, pop_valid, ram_rw);
    end
    model_reset();
    #2;
    clr_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    #1;
    checks++;
    if ({ram_clr, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL async_clr_run got clr=%b cnt=%0d e=%b exp clr=0 cnt=0 e=1", ram_clr, count, empty);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
      #1;
      model_eval();
      checks++;
      if ({push_ready, pop_valid, ram_rw, ram_addr, ram_clr, count, full, empty} !==
          {e_pr, e_pv, e_rw, e_addr, e_clr, 3'(q.size()), q.size() == 4, q.size() == 0}) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got=%b%b%b a=%0d c=%b cnt=%0d exp=%b%b%b a=%0d c=%b cnt=%0d",
                 c, push_ready, pop_valid, ram_rw, ram_addr, ram_clr, count,
                 e_pr, e_pv, e_rw, e_addr, e_clr, q.size());
      end
      if (e_pv) begin
        checks++;
        if (pop_data !== e_pd) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, pop_data, e_pd);
        end
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
